// File: rtl/ahb_out_sched.sv
// ahb_out_sched: AHB-Lite slave that plays a small FIFO of 16-bit values
// out to DataOut/DataValid at a programmable interval.
// Optional feature macro: AHB_OUT_IRQ_EN (adds OutIrq and CTRL bits 2/3).
// Register map (HADDR[3:2]):
//   0x0 DATA   W push [15:0]; R head of FIFO (0 when empty), no pop
//   0x4 PERIOD R/W interval in cycles, 0 behaves as 1
//   0x8 CTRL   bit0 ENABLE, bit1 FLUSH (write-1 action)
//   0xC STATUS bit0 EMPTY, bit1 FULL, bit2 OVERFLOW, [8:4] COUNT; write clears OVERFLOW
module ahb_out_sched #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [15:0] DataOut,
    output logic        DataValid
`ifdef AHB_OUT_IRQ_EN
    ,
    output logic        OutIrq
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    // bus pipeline
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_addr;
    logic             w_setup;
    logic             w_wr_data;
    logic             w_wr_period;
    logic             w_wr_ctrl;
    logic             w_wr_status;
    logic             w_flush;

    // registers
    logic [CNT_W-1:0] r_period;
    logic             r_enable;
    logic             r_overflow;

    // fifo
    logic [15:0]      r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [4:0]       r_count;
    logic             w_empty;
    logic             w_full;
    logic [15:0]      w_head;
    logic             w_push;
    logic             w_push_ok;
    logic             w_pop;

    // sequencer
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_reload;
    logic             w_emit;

    // HSIZE, upper address bits and byte offset carry no meaning here
    logic             w_unused;
    assign w_unused = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA};

    assign HREADYOUT = 1'b1;

    assign w_setup     = HREADY & HSEL & (HTRANS != 2'b00);
    assign w_wr_data   = r_wr & (r_addr == 2'd0);
    assign w_wr_period = r_wr & (r_addr == 2'd1);
    assign w_wr_ctrl   = r_wr & (r_addr == 2'd2);
    assign w_wr_status = r_wr & (r_addr == 2'd3);
    assign w_flush     = w_wr_ctrl & HWDATA[1];

    assign w_empty   = (r_count == 5'd0);
    assign w_full    = (r_count == 5'(DEPTH));
    assign w_head    = r_mem[r_rptr];
    assign w_push    = w_wr_data;
    assign w_pop     = w_emit;
    // a push into a full FIFO only lands if a pop frees a slot on the same edge
    assign w_push_ok = w_push & (~w_full | w_pop);

    // PERIOD of 0 reloads like PERIOD of 1 so emits are never closer than one cycle
    assign w_reload = (r_period == '0) ? '0 : (r_period - CNT_W'(1));

    // latch the address phase; the slave never stalls, so every cycle is a new phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            r_addr <= 2'd0;
        end else begin
            r_wr   <= w_setup & HWRITE;
            r_rd   <= w_setup & ~HWRITE;
            r_addr <= HADDR[3:2];
        end
    end

    // PERIOD, ENABLE and sticky OVERFLOW
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_period   <= '0;
            r_enable   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_period)
                r_period <= HWDATA[CNT_W-1:0];
            if (w_wr_ctrl)
                r_enable <= HWDATA[0];
            if (w_wr_status)
                r_overflow <= 1'b0;
            else if (w_push & w_full & ~w_pop)
                r_overflow <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge HCLK) begin
        if (w_push_ok)
            r_mem[r_wptr] <= HWDATA[15:0];
    end

    // FIFO pointers and occupancy; flush discards everything
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 5'd0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 5'd0;
        end else begin
            if (w_push_ok)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // sequencer state and interval counter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // next state: emit when enabled and data waiting, then count out the interval
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_emit       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_enable && !w_empty) begin
                    w_emit       = 1'b1;
                    w_cnt_next   = w_reload;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else if (r_enable && !w_empty) begin
                    w_emit     = 1'b1;
                    w_cnt_next = w_reload;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // flush overrides any emit on the same edge
        if (w_flush) begin
            w_emit       = 1'b0;
            w_cnt_next   = '0;
            w_state_next = S_IDLE;
        end
    end

    // output pins; flush invalidates but keeps the last value visible
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            DataOut   <= 16'h0000;
            DataValid <= 1'b0;
        end else if (w_flush) begin
            DataValid <= 1'b0;
        end else if (w_emit) begin
            DataOut   <= w_head;
            DataValid <= 1'b1;
        end
    end

`ifdef AHB_OUT_IRQ_EN
    logic r_irq_en;
    logic r_irq;
    logic w_irq_set;

    // last entry leaves the FIFO by a pop while enabled
    assign w_irq_set = w_pop & ~w_push_ok & (r_count == 5'd1) & r_enable & r_irq_en;
    assign OutIrq    = r_irq;

    // interrupt enable and sticky flag; a new drain event beats a same-edge clear
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl)
                r_irq_en <= HWDATA[2];
            if (w_irq_set)
                r_irq <= 1'b1;
            else if (w_wr_ctrl & HWDATA[3])
                r_irq <= 1'b0;
        end
    end
`endif

    // read mux, driven only during a read data phase
    always_comb begin
        HRDATA = 32'h0;
        if (r_rd) begin
            case (r_addr)
                2'd0: HRDATA[15:0] = w_empty ? 16'h0000 : w_head;
                2'd1: HRDATA[CNT_W-1:0] = r_period;
                2'd2: begin
                    HRDATA[0] = r_enable;
`ifdef AHB_OUT_IRQ_EN
                    HRDATA[2] = r_irq_en;
`endif
                end
                default: HRDATA[8:0] = {r_count, 1'b0, r_overflow, w_full, w_empty};
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_out_sched.sv
// Directed bench for ahb_out_sched (DEPTH=4, CNT_W=16, default build).
// A register-access table covers reset values, FIFO fill/overflow and flush;
// hand-written sequences cover emit timing, PERIOD=0, mid-WAIT flush and reset.
module tb_ahb_out_sched;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] HADDR = '0;
    logic [31:0] HWDATA = '0;
    logic [2:0]  HSIZE = 3'b010;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic        HREADY = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [15:0] DataOut;
    logic        DataValid;
`ifdef AHB_OUT_IRQ_EN
    logic        OutIrq;
`endif

    ahb_out_sched #(.DEPTH(4), .CNT_W(16)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HSEL      (HSEL),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .DataOut   (DataOut),
        .DataValid (DataValid)
`ifdef AHB_OUT_IRQ_EN
        ,
        .OutIrq    (OutIrq)
`endif
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // log every change of DataOut with the cycle it appeared in
    typedef struct { int c; logic [15:0] v; } ev_t;
    ev_t evq[$];
    logic [15:0] last_out = 16'h0000;
    always @(negedge HCLK) begin
        if (DataOut !== last_out) begin
            evq.push_back('{cyc, DataOut});
            last_out <= DataOut;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int ev_cyc(input int i);
        return (i < evq.size()) ? evq[i].c : -1;
    endfunction

    function automatic logic [15:0] ev_val(input int i);
        return (i < evq.size()) ? evq[i].v : 16'hxxxx;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    // two-cycle write; returns 1 time unit after the edge that completes the data phase
    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic sel);
        HSEL   = sel;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = {28'h0, addr};
        step(1);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HWDATA = data;
        step(1);
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        HADDR  = {28'h0, addr};
        step(1);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        data   = HRDATA;
        step(1);
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        tbl[24];
    logic [31:0] rd;
    int          c0;
    int          c1;
    int          c3;

    initial begin
        tbl[0]  = '{1'b0, 4'hC, 32'h0,         32'h001,  "rst_status"};
        tbl[1]  = '{1'b0, 4'h4, 32'h0,         32'h000,  "rst_period"};
        tbl[2]  = '{1'b0, 4'h8, 32'h0,         32'h000,  "rst_ctrl"};
        tbl[3]  = '{1'b0, 4'h0, 32'h0,         32'h000,  "rst_data_empty"};
        tbl[4]  = '{1'b1, 4'h4, 32'h0001_0005, 32'h0,    ""};
        tbl[5]  = '{1'b0, 4'h4, 32'h0,         32'h005,  "period_trunc"};
        tbl[6]  = '{1'b1, 4'h0, 32'hAAAA_0101, 32'h0,    ""};
        tbl[7]  = '{1'b1, 4'h0, 32'h0000_0202, 32'h0,    ""};
        tbl[8]  = '{1'b1, 4'h0, 32'h0000_0303, 32'h0,    ""};
        tbl[9]  = '{1'b0, 4'hC, 32'h0,         32'h030,  "status_cnt3"};
        tbl[10] = '{1'b1, 4'h0, 32'h0000_0404, 32'h0,    ""};
        tbl[11] = '{1'b0, 4'hC, 32'h0,         32'h042,  "status_full"};
        tbl[12] = '{1'b1, 4'h0, 32'h0000_0505, 32'h0,    ""};
        tbl[13] = '{1'b0, 4'hC, 32'h0,         32'h046,  "status_ovf"};
        tbl[14] = '{1'b0, 4'h0, 32'h0,         32'h0101, "data_head"};
        tbl[15] = '{1'b0, 4'h0, 32'h0,         32'h0101, "data_head_nopop"};
        tbl[16] = '{1'b1, 4'hC, 32'h0,         32'h0,    ""};
        tbl[17] = '{1'b0, 4'hC, 32'h0,         32'h042,  "ovf_clear"};
        tbl[18] = '{1'b1, 4'h8, 32'h0000_0008, 32'h0,    ""};
        tbl[19] = '{1'b0, 4'h8, 32'h0,         32'h000,  "ctrl_bit3_reads0"};
        tbl[20] = '{1'b1, 4'h8, 32'h0000_0002, 32'h0,    ""};
        tbl[21] = '{1'b0, 4'hC, 32'h0,         32'h001,  "flush_status"};
        tbl[22] = '{1'b0, 4'h0, 32'h0,         32'h000,  "flush_data"};
        tbl[23] = '{1'b0, 4'h8, 32'h0,         32'h000,  "flush_reads0"};

        // reset values while HRESETn is low
        step(3);
        check("rst_dataout", {16'h0, DataOut}, 32'h0);
        check("rst_datavalid", {31'h0, DataValid}, 32'h0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        step(1);

        for (int i = 0; i < 24; i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].addr, tbl[i].data, 1'b1);
            end else begin
                bus_read(tbl[i].addr, rd);
                check(tbl[i].name, rd, tbl[i].exp);
            end
        end

        // unselected transfer must be ignored
        bus_write(4'h4, 32'h0000_0777, 1'b0);
        bus_read(4'h4, rd);
        check("hsel0_ignored", rd, 32'h005);

        // PERIOD=3: two emits exactly 3 cycles apart, first one cycle after ENABLE
        bus_write(4'h4, 32'd3, 1'b1);
        bus_write(4'h0, 32'h1111, 1'b1);
        bus_write(4'h0, 32'h2222, 1'b1);
        evq.delete();
        bus_write(4'h8, 32'h1, 1'b1);
        c0 = cyc;
        step(10);
        check("A_nemits", evq.size(), 2);
        check("A_val0", {16'h0, ev_val(0)}, 32'h1111);
        check("A_cyc0", ev_cyc(0), c0 + 1);
        check("A_val1", {16'h0, ev_val(1)}, 32'h2222);
        check("A_cyc1", ev_cyc(1), c0 + 4);
        check("A_valid", {31'h0, DataValid}, 32'h1);
        bus_read(4'hC, rd);
        check("A_status_drained", rd, 32'h001);

        // overflow with pointers already wrapped, then PERIOD=0 back-to-back emits
        bus_write(4'h8, 32'h0, 1'b1);
        for (int i = 1; i <= 5; i++)
            bus_write(4'h0, 32'h0A00 + i, 1'b1);
        bus_read(4'hC, rd);
        check("B_status_ovf", rd, 32'h046);
        bus_write(4'hC, 32'h0, 1'b1);
        bus_read(4'hC, rd);
        check("B_ovf_clear", rd, 32'h042);
        bus_write(4'h4, 32'd0, 1'b1);
        evq.delete();
        bus_write(4'h8, 32'h1, 1'b1);
        c0 = cyc;
        step(8);
        check("B_nemits", evq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("B_val%0d", i), {16'h0, ev_val(i)}, 32'h0A01 + i);
            check($sformatf("B_cyc%0d", i), ev_cyc(i), c0 + 1 + i);
        end
        bus_read(4'h0, rd);
        check("B_data_empty", rd, 32'h0);

        // flush in the middle of a long interval
        bus_write(4'h4, 32'd10, 1'b1);
        evq.delete();
        bus_write(4'h0, 32'h0B01, 1'b1);
        c1 = cyc;
        bus_write(4'h0, 32'h0B02, 1'b1);
        bus_write(4'h8, 32'h3, 1'b1);
        check("C_valid_cleared", {31'h0, DataValid}, 32'h0);
        check("C_dataout_kept", {16'h0, DataOut}, 32'h0B01);
        bus_read(4'hC, rd);
        check("C_status_flushed", rd, 32'h001);
        bus_read(4'h8, rd);
        check("C_ctrl_enable", rd, 32'h001);
        bus_write(4'h0, 32'h0B03, 1'b1);
        c3 = cyc;
        step(12);
        check("C_nemits", evq.size(), 2);
        check("C_val0", {16'h0, ev_val(0)}, 32'h0B01);
        check("C_cyc0", ev_cyc(0), c1 + 1);
        check("C_val1", {16'h0, ev_val(1)}, 32'h0B03);
        check("C_cyc1", ev_cyc(1), c3 + 1);
        check("C_valid", {31'h0, DataValid}, 32'h1);

        // asynchronous reset while waiting with two entries queued
        bus_write(4'h4, 32'd8, 1'b1);
        bus_write(4'h0, 32'h0C01, 1'b1);
        bus_write(4'h0, 32'h0C02, 1'b1);
        bus_write(4'h0, 32'h0C03, 1'b1);
        bus_read(4'hC, rd);
        check("D_status_cnt2", rd, 32'h020);
        check("D_dataout_pre", {16'h0, DataOut}, 32'h0C01);
        #3;
        HRESETn = 1'b0;
        #1;
        check("D_rst_dataout", {16'h0, DataOut}, 32'h0);
        check("D_rst_datavalid", {31'h0, DataValid}, 32'h0);
        check("D_rst_hrdata", HRDATA, 32'h0);
        step(2);
        @(negedge HCLK);
        HRESETn = 1'b1;
        step(1);
        evq.delete();
        step(20);
        check("D_no_emits", evq.size(), 0);
        bus_read(4'hC, rd);
        check("D_status", rd, 32'h001);
        bus_read(4'h4, rd);
        check("D_period", rd, 32'h0);
        bus_read(4'h8, rd);
        check("D_ctrl", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
